regfile_write_arbiter: RTL and testbench

Round-robin write-port arbiter and clear sequencer for the 8-entry register file. Four requesters share the single write port. The block picks one requester per cycle and drives a registered, one-hot decoded 8-bit write enable together with the write address and write data. After reset, and on command, it walks all eight registers and writes zero to each before it accepts any requests.

---
 rtl/regfile_write_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin write-port arbiter with clear sequencer
// Zeroes all eight registers after reset or clr_start, then grants one requester per cycle.
module regfile_write_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  input  logic [3:0]            req,
  input  logic [11:0]           addr,
  input  logic [4*DATA_W-1:0]   wdata,
  output logic [3:0]            gnt,
  output logic [7:0]            wr_en,
  output logic [2:0]            wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [1:0]  ptr;

  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic [1:0]        cand;
  logic [2:0]        pick_addr;
  logic [DATA_W-1:0] pick_data;

  // Search starts at ptr and wraps, so the requester just served drops to lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    cand       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_addr = 3'd0;
    pick_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (pick_idx == 2'(i)) begin
        pick_addr = addr[3*i +: 3];
        pick_data = wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      cnt     <= 3'd0;
      ptr     <= 2'd0;
      gnt     <= 4'd0;
      wr_en   <= 8'd0;
      wr_addr <= 3'd0;
      wr_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          gnt     <= 4'd0;
          wr_en   <= 8'd1 << cnt;
          wr_addr <= cnt;
          wr_data <= '0;
          cnt     <= cnt + 3'd1;
          // Leaving on the address-7 write lets a waiting req be granted on the very next edge.
          if (cnt == 3'd7) begin
            state <= ARB;
          end
        end
        ARB: begin
          if (clr_start) begin
            state <= CLEAR;
            cnt   <= 3'd0;
            gnt   <= 4'd0;
            wr_en <= 8'd0;
          end else if (pick_valid) begin
            gnt     <= 4'd1 << pick_idx;
            wr_en   <= 8'd1 << pick_addr;
            wr_addr <= pick_addr;
            wr_data <= pick_data;
            ptr     <= pick_idx + 2'd1;
          end else begin
            gnt   <= 4'd0;
            wr_en <= 8'd0;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= 3'd0;
          gnt   <= 4'd0;
          wr_en <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int DATA_W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clr_start = 1'b0;
  logic [3:0]          req = 4'd0;
  logic [11:0]         addr = 12'd0;
  logic [4*DATA_W-1:0] wdata = '0;
  logic [3:0]          gnt;
  logic [7:0]          wr_en;
  logic [2:0]          wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                busy;

  logic [31:0] obs;
  logic [31:0] exp_v;
  int total = 0;
  int bad = 0;

  // Packed observation: {busy, gnt, wr_en, wr_addr, wr_data}
  assign obs = {busy, gnt, wr_en, wr_addr, wr_data};

  regfile_write_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_walk(input string tag);
    for (int e = 0; e < 8; e++) begin
      step();
      exp_v = {(e < 7) ? 1'b1 : 1'b0, 4'b0000, 8'(1 << e), 3'(e), 16'h0000};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL %s edge%0d: got %h want %h", tag, e + 1, obs, exp_v);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_walk("rst_walk");
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 32'h8000_0000) begin
      bad++;
      $display("FAIL reset_now: got %h want %h", obs, 32'h8000_0000);
    end
    step();
    step();
    total++;
    if (obs !== 32'h8000_0000) begin
      bad++;
      $display("FAIL reset_held: got %h want %h", obs, 32'h8000_0000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clear_seq();
    clear_walk("clear_seq");
    step();
    exp_v = {1'b0, 4'b0000, 8'h00, 3'd7, 16'h0000};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL clear_edge9: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_single();
    req = 4'b0001;
    addr = 12'h003;
    wdata = 64'h0000_0000_0000_A5A5;
    step();
    req = 4'b0000;
    exp_v = {1'b0, 4'b0001, 8'h08, 3'd3, 16'hA5A5};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL single_grant: got %h want %h", obs, exp_v);
    end
    step();
    exp_v = {1'b0, 4'b0000, 8'h00, 3'd3, 16'hA5A5};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL single_idle: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] d;
    addr = {3'd7, 3'd6, 3'd5, 3'd4};
    wdata = 64'h1003_1002_1001_1000;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      d = 16'h1000 + 16'(k % 4);
      exp_v = {1'b0, 4'(1 << (k % 4)), 8'(1 << ((k % 4) + 4)), 3'((k % 4) + 4), d};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL rr_grant%0d: got %h want %h", k, obs, exp_v);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_clr_priority();
    req = 4'b0100;
    addr = 12'h140;
    wdata = 64'h0000_BEEF_0000_0000;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    total++;
    if (gnt !== 4'b0000 || wr_en !== 8'h00 || busy !== 1'b1) begin
      bad++;
      $display("FAIL clr_accept: got gnt=%b wr_en=%h busy=%b want 0000 00 1", gnt, wr_en, busy);
    end
    clear_walk("clr_walk");
    step();
    req = 4'b0000;
    exp_v = {1'b0, 4'b0100, 8'h20, 3'd5, 16'hBEEF};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL clr_then_grant: got %h want %h", obs, exp_v);
    end
    step();
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int e = 0; e < 5; e++) step();
    total++;
    if (wr_en !== 8'h10 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got wr_en=%h busy=%b want 10 1", wr_en, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 32'h8000_0000) begin
      bad++;
      $display("FAIL mid_async: got %h want %h", obs, 32'h8000_0000);
    end
    step();
    rst_n = 1'b1;
    clear_walk("mid_restart");
    step();
  endtask

  task automatic test_ptr_hold();
    addr = 12'h000;
    wdata = '0;
    req = 4'b0100;
    step();
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL ptr_first: got %b want 0100", gnt);
    end
    req = 4'b0000;
    step();
    total++;
    if (gnt !== 4'b0000 || wr_en !== 8'h00) begin
      bad++;
      $display("FAIL ptr_idle: got gnt=%b wr_en=%h want 0000 00", gnt, wr_en);
    end
    req = 4'b0011;
    step();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL ptr_wrap: got %b want 0001", gnt);
    end
    req = 4'b0010;
    step();
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL ptr_next: got %b want 0010", gnt);
    end
    req = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_clear_seq();
    test_single();
    do_reset();
    test_round_robin();
    test_clr_priority();
    test_reset_mid();
    test_ptr_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
